// File: rtl/ccc_handler_pkg.sv
// ---------------------------------------------------------------------------
// ccc_handler_pkg: CCC codes, FSM state encoding and per-code length table.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ccc_handler_pkg;

  localparam logic [7:0] CCC_ENEC_B      = 8'h00;
  localparam logic [7:0] CCC_DISEC_B     = 8'h01;
  localparam logic [7:0] CCC_SETMWL_B    = 8'h09;
  localparam logic [7:0] CCC_SETMRL_B    = 8'h0A;
  localparam logic [7:0] CCC_ENTHDR0     = 8'h20;
  localparam logic [7:0] CCC_RSTACT_B    = 8'h2A;
  localparam logic [7:0] CCC_ENEC_D      = 8'h80;
  localparam logic [7:0] CCC_DISEC_D     = 8'h81;
  localparam logic [7:0] CCC_SETMWL_D    = 8'h89;
  localparam logic [7:0] CCC_SETMRL_D    = 8'h8A;
  localparam logic [7:0] CCC_GETMWL      = 8'h8B;
  localparam logic [7:0] CCC_GETMRL      = 8'h8C;
  localparam logic [7:0] CCC_GETSTATUS   = 8'h90;
  localparam logic [7:0] CCC_RSTACT_D    = 8'h9A;

  typedef logic [2:0] ccc_state_e;
  localparam ccc_state_e ST_IDLE     = 3'd0;
  localparam ccc_state_e ST_BCAST    = 3'd1;
  localparam ccc_state_e ST_DIR_WAIT = 3'd2;
  localparam ccc_state_e ST_DIR_RX   = 3'd3;
  localparam ccc_state_e ST_DIR_TX   = 3'd4;
  localparam ccc_state_e ST_SKIP     = 3'd5;

  // dir: 1 = GET (target transmits), 0 = SET/write
  typedef struct packed {
    logic [3:0] len_min;
    logic [3:0] len_max;
    logic       dir;
  } ccc_len_t;

  typedef struct packed {
    logic     supported;
    ccc_len_t len;
  } ccc_info_t;

  function automatic ccc_info_t ccc_lookup(input logic [7:0] code);
    ccc_info_t info;
    info           = '0;
    info.supported = 1'b1;
    case (code)
      CCC_ENEC_B, CCC_ENEC_D, CCC_DISEC_B, CCC_DISEC_D,
      CCC_RSTACT_B, CCC_RSTACT_D: begin
        info.len.len_min = 4'd1;
        info.len.len_max = 4'd1;
      end
      CCC_ENTHDR0: ;
      CCC_SETMWL_B, CCC_SETMWL_D: begin
        info.len.len_min = 4'd2;
        info.len.len_max = 4'd2;
      end
      CCC_SETMRL_B, CCC_SETMRL_D: begin
        info.len.len_min = 4'd2;
        info.len.len_max = 4'd3;
      end
      CCC_GETMWL, CCC_GETMRL, CCC_GETSTATUS: info.len.dir = 1'b1;
      default: info.supported = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic ccc_supported(input logic [7:0] code);
    ccc_info_t info;
    info = ccc_lookup(code);
    return info.supported;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccc_handler_resp_serializer.sv
// ---------------------------------------------------------------------------
// ccc_resp_serializer: streams a preloaded response MSB-first over valid/ready.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccc_resp_serializer #(
  parameter int unsigned MaxTxBytes = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [MaxTxBytes*8-1:0] data_i,
  input  logic                    abort_i,
  input  logic                    tx_ready_i,
  output logic                    tx_valid_o,
  output logic [7:0]              tx_byte_o,
  output logic                    tx_last_o,
  output logic                    done_o
);

  localparam int unsigned IdxW = (MaxTxBytes > 1) ? $clog2(MaxTxBytes) : 1;

  logic [MaxTxBytes*8-1:0] shift_q, shift_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    valid_q, valid_d;
  logic                    accept;
  logic                    last;

  assign accept = valid_q && tx_ready_i;
  assign last   = valid_q && (idx_q == IdxW'(MaxTxBytes - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (abort_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      shift_d = data_i;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shift_d = shift_q << 8;
      idx_d   = idx_q + 1'b1;
      if (last) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_byte_o  = shift_q[MaxTxBytes*8-1 -: 8];
  assign tx_last_o  = last;
  assign done_o     = accept && last && !abort_i;

endmodule

`default_nettype wire

// File: rtl/ccc_handler.sv
// ---------------------------------------------------------------------------
// ccc_handler: CCC frame tracker, SET-payload commit and GET response source.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccc_handler
  import ccc_handler_pkg::*;
#(
  parameter int unsigned MaxRxBytes = 3,
  parameter int unsigned MaxTxBytes = 2,
  parameter logic [15:0] DefaultMrl = 16'd256,
  parameter logic [15:0] DefaultMwl = 16'd256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ccc_valid_i,
  input  logic [7:0]  ccc_code_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        addr_valid_i,
  input  logic        addr_match_i,
  input  logic        rnw_i,
  output logic        addr_ack_o,
  input  logic        done_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_last_o,
  input  logic [15:0] status_i,
  output logic [15:0] mrl_o,
  output logic [15:0] mwl_o,
  output logic [7:0]  rst_action_o,
  input  logic        rst_action_clr_i,
  output logic [3:0]  events_en_o,
  output logic        hdr_mode_o,
  input  logic        hdr_exit_i,
  output logic        err_o
);

  // Counter reaches MaxRxBytes+1 so an overlong payload still fails the max check.
  localparam int unsigned CntW = $clog2(MaxRxBytes + 2);

  ccc_state_e              state_q, state_d;
  logic [7:0]              code_q, code_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [15:0]             payload_q, payload_d;
  logic [7:0]              def_q, def_d;
  logic                    def_seen_q, def_seen_d;
  logic [15:0]             mrl_q, mrl_d;
  logic [15:0]             mwl_q, mwl_d;
  logic [7:0]              rst_action_q, rst_action_d;
  logic [3:0]              events_en_q, events_en_d;
  logic                    hdr_mode_q, hdr_mode_d;
  logic                    err_q, err_d;

  ccc_info_t               cur_info;
  logic                    len_err;
  logic                    frame_end;
  logic                    ser_load, ser_abort, ser_done;
  logic [15:0]             resp;
  logic [MaxTxBytes*8-1:0] ser_data;

  assign cur_info = ccc_lookup(code_q);
  assign len_err  = (32'(cnt_q) < 32'(cur_info.len.len_min)) ||
                    (32'(cnt_q) > 32'(cur_info.len.len_max));

  assign addr_ack_o = (state_q == ST_DIR_WAIT) && addr_valid_i && addr_match_i &&
                      (rnw_i == cur_info.len.dir);

  always_comb begin
    resp = 16'h0000;
    case (code_q)
      CCC_GETMWL:    resp = mwl_q;
      CCC_GETMRL:    resp = mrl_q;
      CCC_GETSTATUS: resp = status_i;
      default:       resp = 16'h0000;
    endcase
    ser_data = '0;
    ser_data[MaxTxBytes*8-1 -: 16] = resp;
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    payload_d    = payload_q;
    def_d        = def_q;
    def_seen_d   = def_seen_q;
    mrl_d        = mrl_q;
    mwl_d        = mwl_q;
    events_en_d  = events_en_q;
    rst_action_d = rst_action_clr_i ? 8'h00 : rst_action_q;
    hdr_mode_d   = hdr_mode_q;
    err_d        = 1'b0;
    ser_load     = 1'b0;
    ser_abort    = 1'b0;
    frame_end    = 1'b0;

    // Only the first two payload bytes carry meaning; later ones are just counted.
    if (rx_valid_i && (state_q == ST_BCAST || state_q == ST_DIR_RX)) begin
      if (cnt_q == CntW'(0)) payload_d[15:8] = rx_byte_i;
      if (cnt_q == CntW'(1)) payload_d[7:0]  = rx_byte_i;
      if (cnt_q <= CntW'(MaxRxBytes)) cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_BCAST: begin
        if (done_i) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DIR_WAIT: begin
        if (rx_valid_i && code_q == CCC_RSTACT_D && !def_seen_q) begin
          def_d      = rx_byte_i;
          def_seen_d = 1'b1;
        end
        if (done_i) begin
          state_d = ST_IDLE;
        end else if (addr_ack_o) begin
          if (cur_info.len.dir) begin
            ser_load = 1'b1;
            state_d  = ST_DIR_TX;
          end else begin
            state_d = ST_DIR_RX;
            cnt_d   = '0;
            // Direct RSTACT: the defining byte sent before the address is the payload.
            if (code_q == CCC_RSTACT_D && def_seen_q) begin
              payload_d[15:8] = def_q;
              cnt_d           = CntW'(1);
            end
          end
        end
      end
      ST_DIR_RX: begin
        if (done_i || addr_valid_i) begin
          frame_end = 1'b1;
          state_d   = done_i ? ST_IDLE : ST_DIR_WAIT;
        end
      end
      ST_DIR_TX: begin
        if (done_i || addr_valid_i) begin
          ser_abort = 1'b1;
          state_d   = done_i ? ST_IDLE : ST_DIR_WAIT;
        end else if (ser_done) begin
          state_d = ST_DIR_WAIT;
        end
      end
      ST_SKIP: begin
        if (done_i) state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    if (frame_end && cur_info.supported) begin
      if (len_err) begin
        err_d = 1'b1;
      end else begin
        case (code_q)
          CCC_ENEC_B, CCC_ENEC_D:     events_en_d  = events_en_q | payload_q[11:8];
          CCC_DISEC_B, CCC_DISEC_D:   events_en_d  = events_en_q & ~payload_q[11:8];
          CCC_RSTACT_B, CCC_RSTACT_D: rst_action_d = payload_q[15:8];
          CCC_SETMWL_B, CCC_SETMWL_D: mwl_d        = payload_q;
          CCC_SETMRL_B, CCC_SETMRL_D: mrl_d        = payload_q;
          default: ;
        endcase
      end
    end

    // A new code always restarts decode; any commit above has already closed the old frame.
    if (ccc_valid_i) begin
      if (state_q == ST_DIR_TX) ser_abort = 1'b1;
      ser_load   = 1'b0;
      code_d     = ccc_code_i;
      cnt_d      = '0;
      def_seen_d = 1'b0;
      if (!ccc_supported(ccc_code_i)) begin
        state_d = ST_SKIP;
      end else if (ccc_code_i[7]) begin
        state_d = ST_DIR_WAIT;
      end else begin
        state_d = ST_BCAST;
        if (ccc_code_i == CCC_ENTHDR0) hdr_mode_d = 1'b1;
      end
    end

    if (hdr_exit_i) hdr_mode_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      code_q       <= 8'h00;
      cnt_q        <= '0;
      payload_q    <= 16'h0000;
      def_q        <= 8'h00;
      def_seen_q   <= 1'b0;
      mrl_q        <= DefaultMrl;
      mwl_q        <= DefaultMwl;
      rst_action_q <= 8'h00;
      events_en_q  <= 4'hF;
      hdr_mode_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      payload_q    <= payload_d;
      def_q        <= def_d;
      def_seen_q   <= def_seen_d;
      mrl_q        <= mrl_d;
      mwl_q        <= mwl_d;
      rst_action_q <= rst_action_d;
      events_en_q  <= events_en_d;
      hdr_mode_q   <= hdr_mode_d;
      err_q        <= err_d;
    end
  end

  ccc_resp_serializer #(
    .MaxTxBytes (MaxTxBytes)
  ) u_resp_serializer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ser_load),
    .data_i     (ser_data),
    .abort_i    (ser_abort),
    .tx_ready_i (tx_ready_i),
    .tx_valid_o (tx_valid_o),
    .tx_byte_o  (tx_byte_o),
    .tx_last_o  (tx_last_o),
    .done_o     (ser_done)
  );

  assign mrl_o        = mrl_q;
  assign mwl_o        = mwl_q;
  assign rst_action_o = rst_action_q;
  assign events_en_o  = events_en_q;
  assign hdr_mode_o   = hdr_mode_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ccc_handler.sv
// ---------------------------------------------------------------------------
// tb_ccc_handler: directed and random CCC frames against a frame-level model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ccc_handler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ccc_valid_i, rx_valid_i, addr_valid_i, addr_match_i, rnw_i;
  logic [7:0]  ccc_code_i, rx_byte_i;
  logic        addr_ack_o, done_i, tx_valid_o, tx_ready_i, tx_last_o;
  logic [7:0]  tx_byte_o, rst_action_o;
  logic [15:0] status_i, mrl_o, mwl_o;
  logic        rst_action_clr_i, hdr_mode_o, hdr_exit_i, err_o;
  logic [3:0]  events_en_o;

  always #5 clk_i = ~clk_i;

  ccc_handler dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ccc_valid_i      (ccc_valid_i),
    .ccc_code_i       (ccc_code_i),
    .rx_valid_i       (rx_valid_i),
    .rx_byte_i        (rx_byte_i),
    .addr_valid_i     (addr_valid_i),
    .addr_match_i     (addr_match_i),
    .rnw_i            (rnw_i),
    .addr_ack_o       (addr_ack_o),
    .done_i           (done_i),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .tx_byte_o        (tx_byte_o),
    .tx_last_o        (tx_last_o),
    .status_i         (status_i),
    .mrl_o            (mrl_o),
    .mwl_o            (mwl_o),
    .rst_action_o     (rst_action_o),
    .rst_action_clr_i (rst_action_clr_i),
    .events_en_o      (events_en_o),
    .hdr_mode_o       (hdr_mode_o),
    .hdr_exit_i       (hdr_exit_i),
    .err_o            (err_o)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  logic [15:0] exp_mrl, exp_mwl;
  logic [7:0]  exp_rst;
  logic [3:0]  exp_ev;
  logic        exp_hdr;
  logic [7:0]  pl[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_mrl = 16'd256;
    exp_mwl = 16'd256;
    exp_rst = 8'h00;
    exp_ev  = 4'hF;
    exp_hdr = 1'b0;
  endtask

  // Applies a completed write payload for a code per the CCC length/effect table.
  task automatic model_write(input logic [7:0] code, output logic err);
    int  lo, hi, n;
    bit  known;
    logic [7:0] b0, b1;
    known = 1;
    lo = 0;
    hi = 0;
    n  = pl.size();
    b0 = (n > 0) ? pl[0] : 8'h00;
    b1 = (n > 1) ? pl[1] : 8'h00;
    case (code)
      8'h00, 8'h80, 8'h01, 8'h81, 8'h2A, 8'h9A: begin lo = 1; hi = 1; end
      8'h20:                                   begin lo = 0; hi = 0; end
      8'h09, 8'h89:                            begin lo = 2; hi = 2; end
      8'h0A, 8'h8A:                            begin lo = 2; hi = 3; end
      default: known = 0;
    endcase
    err = known && (n < lo || n > hi);
    if (known && !err) begin
      case (code)
        8'h00, 8'h80: exp_ev  = exp_ev | b0[3:0];
        8'h01, 8'h81: exp_ev  = exp_ev & ~b0[3:0];
        8'h2A, 8'h9A: exp_rst = b0;
        8'h09, 8'h89: exp_mwl = {b0, b1};
        8'h0A, 8'h8A: exp_mrl = {b0, b1};
        default: ;
      endcase
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_mrl"}, 32'(mrl_o), 32'(exp_mrl));
    check_eq({tag, "_mwl"}, 32'(mwl_o), 32'(exp_mwl));
    check_eq({tag, "_ev"},  32'(events_en_o), 32'(exp_ev));
    check_eq({tag, "_rst"}, 32'(rst_action_o), 32'(exp_rst));
    check_eq({tag, "_hdr"}, 32'(hdr_mode_o), 32'(exp_hdr));
  endtask

  task automatic send_ccc(input logic [7:0] c);
    ccc_valid_i = 1'b1;
    ccc_code_i  = c;
    @(negedge clk_i);
    ccc_valid_i = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_addr(input logic m, input logic r, output logic ack);
    addr_valid_i = 1'b1;
    addr_match_i = m;
    rnw_i        = r;
    #1 ack = addr_ack_o;
    @(negedge clk_i);
    addr_valid_i = 1'b0;
  endtask

  task automatic send_done();
    done_i = 1'b1;
    @(negedge clk_i);
    done_i = 1'b0;
  endtask

  task automatic rand_payload(input int lo, input int hi);
    int n;
    pl.delete();
    n = $urandom_range(hi, lo);
    repeat (n) pl.push_back(8'($urandom));
  endtask

  task automatic run_bcast(input logic [7:0] c, input string tag);
    logic e;
    send_ccc(c);
    if (c == 8'h20) exp_hdr = 1'b1;
    foreach (pl[i]) send_rx(pl[i]);
    send_done();
    model_write(c, e);
    check_eq({tag, "_err"}, 32'(err_o), 32'(e));
    check_regs(tag);
  endtask

  task automatic run_dir_wr(input logic [7:0] c, input int nnack, input string tag);
    logic ack, e, m, r;
    send_ccc(c);
    for (int k = 0; k < nnack; k++) begin
      m = 1'($urandom);
      r = m ? 1'b1 : 1'($urandom);
      send_addr(m, r, ack);
      check_eq({tag, "_nack"}, 32'(ack), 32'(0));
      send_rx(8'($urandom));
    end
    send_addr(1'b1, 1'b0, ack);
    check_eq({tag, "_ack"}, 32'(ack), 32'(1));
    foreach (pl[i]) send_rx(pl[i]);
    send_done();
    model_write(c, e);
    check_eq({tag, "_err"}, 32'(err_o), 32'(e));
    check_regs(tag);
  endtask

  task automatic tx_collect(input logic [15:0] exp, input string tag);
    int   idx;
    int   budget;
    logic rdy;
    idx    = 0;
    budget = 0;
    while (idx < 2 && budget < 40) begin
      rdy = 1'b0;
      if (tx_valid_o) begin
        rdy = ($urandom_range(2, 0) != 0);
        if (rdy) begin
          check_eq({tag, "_byte"}, 32'(tx_byte_o), 32'((idx == 0) ? exp[15:8] : exp[7:0]));
          check_eq({tag, "_last"}, 32'(tx_last_o), 32'(idx == 1));
          idx++;
        end
      end
      tx_ready_i = rdy;
      @(negedge clk_i);
      tx_ready_i = 1'b0;
      budget++;
    end
    check_eq({tag, "_count"}, 32'(idx), 32'(2));
    check_eq({tag, "_vdrop"}, 32'(tx_valid_o), 32'(0));
  endtask

  task automatic run_get(input logic [7:0] c, input int stall, input string tag);
    logic        ack;
    logic [15:0] st, exp;
    st       = 16'($urandom);
    status_i = st;
    send_ccc(c);
    send_addr(1'b1, 1'b0, ack);
    check_eq({tag, "_wrnack"}, 32'(ack), 32'(0));
    send_addr(1'b1, 1'b1, ack);
    check_eq({tag, "_ack"}, 32'(ack), 32'(1));
    exp      = (c == 8'h8B) ? exp_mwl : (c == 8'h8C) ? exp_mrl : st;
    status_i = 16'($urandom);
    check_eq({tag, "_valid"}, 32'(tx_valid_o), 32'(1));
    repeat (stall) begin
      check_eq({tag, "_hold"}, 32'(tx_byte_o), 32'(exp[15:8]));
      @(negedge clk_i);
    end
    tx_collect(exp, tag);
    send_done();
    check_eq({tag, "_err"}, 32'(err_o), 32'(0));
    check_regs(tag);
  endtask

  initial begin
    logic       ack, e;
    logic [7:0] c;
    int         sel;
    rst_ni = 1'b0;
    ccc_valid_i = 0; ccc_code_i = 0; rx_valid_i = 0; rx_byte_i = 0;
    addr_valid_i = 0; addr_match_i = 0; rnw_i = 0; done_i = 0;
    tx_ready_i = 0; status_i = 0; rst_action_clr_i = 0; hdr_exit_i = 0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_regs("reset");
    check_eq("reset_txv", 32'(tx_valid_o), 32'(0));
    check_eq("reset_err", 32'(err_o), 32'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);

    // GETMRL after reset with a 3-cycle ready stall
    run_get(8'h8C, 3, "getmrl_rst");
    check_eq("getmrl_rst_val", 32'(mrl_o), 32'h0100);

    // Direct SETMWL
    pl = '{8'h01, 8'h40};
    run_dir_wr(8'h89, 0, "setmwl");
    check_eq("setmwl_val", 32'(mwl_o), 32'h0140);

    // Broadcast SETMRL too short / too long
    pl = '{8'h12};
    run_bcast(8'h0A, "setmrl_short");
    check_eq("setmrl_short_mrl", 32'(mrl_o), 32'h0100);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_bcast(8'h0A, "setmrl_long");
    check_eq("setmrl_long_err", 32'(err_o), 32'(1));
    @(negedge clk_i);
    check_eq("err_pulse_end", 32'(err_o), 32'(0));

    // DISEC then ENEC, RSTACT, clear
    pl = '{8'h0B};
    run_bcast(8'h01, "disec");
    check_eq("disec_val", 32'(events_en_o), 32'h4);
    run_bcast(8'h00, "enec");
    check_eq("enec_val", 32'(events_en_o), 32'hF);
    pl = '{8'h01};
    run_bcast(8'h2A, "rstact");
    check_eq("rstact_val", 32'(rst_action_o), 32'h01);
    rst_action_clr_i = 1'b1;
    @(negedge clk_i);
    rst_action_clr_i = 1'b0;
    exp_rst = 8'h00;
    check_regs("rstclr");

    // NACKed direct target followed by our address
    pl = '{8'h00, 8'h20};
    run_dir_wr(8'h89, 1, "setmwl_sr");
    check_eq("setmwl_sr_val", 32'(mwl_o), 32'h0020);

    // done_i and ccc_valid_i in the same cycle
    send_ccc(8'h09);
    pl = '{8'h12, 8'h34};
    foreach (pl[i]) send_rx(pl[i]);
    done_i = 1'b1; ccc_valid_i = 1'b1; ccc_code_i = 8'h00;
    @(negedge clk_i);
    done_i = 1'b0; ccc_valid_i = 1'b0;
    model_write(8'h09, e);
    check_eq("overlap_err", 32'(err_o), 32'(e));
    check_eq("overlap_mwl", 32'(mwl_o), 32'h1234);
    pl = '{8'h01};
    send_rx(8'h01);
    send_done();
    model_write(8'h00, e);
    check_regs("overlap_next");

    // hdr_exit wins over ENTHDR0 in the same cycle
    hdr_exit_i = 1'b1;
    send_ccc(8'h20);
    hdr_exit_i = 1'b0;
    check_eq("hdr_prio", 32'(hdr_mode_o), 32'(0));
    send_done();
    pl.delete();
    run_bcast(8'h20, "enthdr");
    hdr_exit_i = 1'b1;
    @(negedge clk_i);
    hdr_exit_i = 1'b0;
    exp_hdr = 1'b0;
    check_regs("hdr_exit");

    // Unknown code is skipped
    pl = '{8'h0A, 8'h00, 8'h00};
    run_bcast(8'h7F, "skip");

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(3, 0);
      case (sel)
        0: begin
          case ($urandom_range(7, 0))
            0: c = 8'h00; 1: c = 8'h01; 2: c = 8'h20; 3: c = 8'h2A;
            4: c = 8'h09; 5: c = 8'h0A; 6: c = 8'h7F; default: c = 8'h55;
          endcase
          rand_payload(0, 4);
          run_bcast(c, "rnd_bcast");
        end
        1: begin
          case ($urandom_range(3, 0))
            0: c = 8'h80; 1: c = 8'h81; 2: c = 8'h89; default: c = 8'h8A;
          endcase
          rand_payload(0, 4);
          run_dir_wr(c, $urandom_range(2, 0), "rnd_dir");
        end
        2: begin
          case ($urandom_range(2, 0))
            0: c = 8'h8B; 1: c = 8'h8C; default: c = 8'h90;
          endcase
          run_get(c, $urandom_range(2, 0), "rnd_get");
        end
        default: begin
          if ($urandom_range(1, 0) == 0) begin
            rst_action_clr_i = 1'b1; exp_rst = 8'h00;
          end else begin
            hdr_exit_i = 1'b1; exp_hdr = 1'b0;
          end
          @(negedge clk_i);
          rst_action_clr_i = 1'b0;
          hdr_exit_i = 1'b0;
          check_regs("rnd_misc");
        end
      endcase
    end

    // Reset in the middle of a GETSTATUS response
    status_i = 16'hABCD;
    send_ccc(8'h90);
    send_addr(1'b1, 1'b1, ack);
    check_eq("getst_ack", 32'(ack), 32'(1));
    check_eq("getst_valid", 32'(tx_valid_o), 32'(1));
    check_eq("getst_byte", 32'(tx_byte_o), 32'hAB);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_txv", 32'(tx_valid_o), 32'(0));
    check_eq("midrst_err", 32'(err_o), 32'(0));
    check_regs("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_get(8'h8B, 0, "post_rst_get");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ccc_handler.md
# ccc_handler

Parametrised successor to the single-byte CCC decoder. Tracks a whole CCC frame: the broadcast code, then any defining or data bytes, then per-target direct phases. It commits SET-type payloads to registers and serves GET-type responses as a byte stream. It sits between the target-side bus FSM (code, byte and address events) and the CSR/queue logic (MRL/MWL, reset action, event enables).

## Interface
Parameters:
- `MaxRxBytes`, default 3: largest accepted write payload in bytes, defining byte included.
- `MaxTxBytes`, default 2: largest GET response in bytes.
- `DefaultMrl`, default 16'd256: reset value of `mrl_o`.
- `DefaultMwl`, default 16'd256: reset value of `mwl_o`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `ccc_valid_i` in 1: pulse; `ccc_code_i` holds a new CCC code.
- `ccc_code_i` in 8: CCC code.
- `rx_valid_i` in 1: pulse; `rx_byte_i` is a received data or defining byte. No backpressure.
- `rx_byte_i` in 8: received byte.
- `addr_valid_i` in 1: pulse at each direct-phase address byte.
- `addr_match_i` in 1: the address equals our dynamic address.
- `rnw_i` in 1: read/not-write bit of that address.
- `addr_ack_o` out 1: combinational ACK decision, valid while `addr_valid_i` is high.
- `done_i` in 1: pulse on STOP; the frame ends.
- `tx_valid_o` out 1, `tx_ready_i` in 1, `tx_byte_o` out 8, `tx_last_o` out 1: response stream with valid/ready handshake.
- `status_i` in 16: GETSTATUS payload, sampled at response start.
- `mrl_o` out 16: maximum read length register.
- `mwl_o` out 16: maximum write length register.
- `rst_action_o` out 8: latched reset action.
- `rst_action_clr_i` in 1: clears `rst_action_o`.
- `events_en_o` out 4: event enables.
- `hdr_mode_o` out 1: HDR mode entered.
- `hdr_exit_i` in 1: leaves HDR mode.
- `err_o` out 1: one-cycle pulse on a payload length violation.

## Operation
Supported codes:
- ENEC 0x00/0x80: events_en |= byte0[3:0].
- DISEC 0x01/0x81: events_en &= ~byte0[3:0].
- ENTHDR0 0x20: no payload.
- RSTACT 0x2A/0x9A: 1 byte (the defining byte).
- SETMWL 0x09/0x89: 2 bytes, MSB first.
- SETMRL 0x0A/0x8A: 2–3 bytes; byte 2 is ignored.
- GETMWL 0x8B, GETMRL 0x8C, GETSTATUS 0x90: 2-byte responses, MSB first.

Each code carries a min/max length. Bytes received beyond `MaxRxBytes` are dropped, and the counter saturates.

FSM states: IDLE, BCAST, DIR_WAIT, DIR_RX, DIR_TX, SKIP.
- IDLE, `ccc_valid_i` with code[7]=0:
  - supported code -> BCAST; ENTHDR0 sets `hdr_mode_o` immediately.
  - unsupported code -> SKIP.
- IDLE, `ccc_valid_i` with code[7]=1:
  - RSTACT 0x9A -> DIR_WAIT; the first rx byte is latched as the defining byte.
  - other supported code -> DIR_WAIT.
  - unsupported code -> SKIP.
- BCAST: counts rx bytes. `done_i` -> length check -> commit or `err_o` -> IDLE.
- DIR_WAIT, `addr_valid_i`:
  - `addr_match_i` and rnw equal to code direction (GET=1, else 0) -> `addr_ack_o`=1, then DIR_TX or DIR_RX.
  - anything else -> NACK, stay in DIR_WAIT.
- DIR_RX: a new `addr_valid_i` (repeated START) or `done_i` ends our payload -> commit/check -> DIR_WAIT, or IDLE on `done_i`.
- DIR_TX: response is loaded at entry. Each accepted byte advances the index; `tx_last_o` is high on index `MaxTxBytes-1`. After the last accept -> DIR_WAIT.
  - `done_i` or `addr_valid_i` mid-response aborts silently: no error, `tx_valid_o` drops.
- SKIP: ignores everything until `done_i`.
- Any state: `ccc_valid_i` while not IDLE aborts the current frame without commit and restarts decode.
- Length check: count < min or count > max (counted before saturation, saturating at `MaxRxBytes`+1) -> `err_o`, no register update.
- `mrl_o`/`mwl_o` accept any 16-bit value; no clamping.

## Timing
- Reset values:
  - `mrl_o`=`DefaultMrl`, `mwl_o`=`DefaultMwl`.
  - `events_en_o`=4'hF, `rst_action_o`=0.
  - `hdr_mode_o`=0, `tx_valid_o`=0, `err_o`=0.
  - FSM in IDLE.
- Registers and `err_o` update 1 cycle after the terminating `done_i`/`addr_valid_i`.
- `tx_valid_o` rises 1 cycle after the acked read address. Each byte is held until `tx_ready_i`.
- `done_i` together with `ccc_valid_i`: close the old frame (commit), then start the new one in the same edge.
- `rst_action_clr_i` together with an RSTACT commit: the commit wins.
- `hdr_exit_i` has priority over ENTHDR0 in the same cycle.

## Structure
- Add to `i3c_pkg`:
  - the missing CCC code defines;
  - `ccc_state_e`;
  - a `ccc_len_t` struct {min, max, dir};
  - function `ccc_lookup(code)` returning `ccc_len_t` and a supported flag.
- Sub-module `ccc_resp_serializer`: loads a `MaxTxBytes`×8 vector, drives valid/ready/last, and accepts an abort input.

## Test plan
- SETMWL 0x89: ack, rx 0x01,0x40, `done_i` -> `mwl_o`=16'h0140 next cycle, `err_o`=0.
- GETMRL 0x8C after reset: read ack -> tx 0x01, then 0x00 with `tx_last_o`; `tx_ready_i` stalled 3 cycles holds byte 0x01.
- Broadcast SETMRL with 1 byte, then `done_i` -> `err_o` pulse, `mrl_o` stays 0x0100. With 4 bytes -> `err_o`.
- ENEC 0x00 after DISEC 0x01 of 0x0B -> `events_en_o` 4'h4 then 4'hF. Then RSTACT 0x2A defining 0x01 -> `rst_action_o`=0x01; `rst_action_clr_i` -> 0.
- Direct SETMWL to 0x12 (not matched: NACK, bytes ignored), then repeated START to our address with bytes 0x00,0x20 -> `mwl_o`=0x0020.
- Reset asserted mid-GETSTATUS -> `tx_valid_o`=0, all outputs at reset values; unknown code 0x7F -> SKIP, no side effects.
